// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requester agents and the round-robin arbiter.
// The arbiter connects through the slave modport; the agents drive the master side.
interface rr_arbiter_if #(
    parameter int NUM_REQ = 32,
    parameter int IDX_W   = 5
);
    logic [NUM_REQ-1:0] req_i;
    logic               done_i;
    logic [NUM_REQ-1:0] gnt_o;
    logic [IDX_W-1:0]   gnt_idx_o;
    logic               gnt_valid_o;
    logic               timeout_o;

    modport master (
        output req_i,
        output done_i,
        input  gnt_o,
        input  gnt_idx_o,
        input  gnt_valid_o,
        input  timeout_o
    );

    modport slave (
        input  req_i,
        input  done_i,
        output gnt_o,
        output gnt_idx_o,
        output gnt_valid_o,
        output timeout_o
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer, grant-hold handshake
// and a hold-timeout watchdog that forcibly revokes an over-long grant.
module rr_arbiter #(
    parameter int NUM_REQ  = 32,
    parameter int IDX_W    = 5,
    parameter int MAX_HOLD = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    rr_arbiter_if.slave       bus
);
    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;

    logic [NUM_REQ-1:0] ptr_mask;
    logic [NUM_REQ-1:0] masked;
    logic [IDX_W-1:0]   winner;
    logic               hold_expire;
    logic               release_now;

    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            ptr_mask[i] = (IDX_W'(i) >= ptr_q);
        end
    end

    // Requests at or above the pointer win first; otherwise wrap to the lowest index.
    assign masked      = bus.req_i & ptr_mask;
    assign winner      = (|masked) ? lowest_set(masked) : lowest_set(bus.req_i);
    assign hold_expire = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
    assign release_now = bus.done_i || !bus.req_i[idx_q] || hold_expire;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|bus.req_i) begin
                    state_d = GRANT;
                    gnt_d   = NUM_REQ'(1) << winner;
                    idx_d   = winner;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    ptr_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    // Pulse only when the watchdog alone forced the release.
                    timeout_d = hold_expire && !bus.done_i && bus.req_i[idx_q];
                end else if (MAX_HOLD != 0 && cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so all update together at the edge.
        if (!rst_ni) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.gnt_idx_o   = idx_q;
    assign bus.gnt_valid_o = (state_q == GRANT);
    assign bus.timeout_o   = timeout_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: rotation order, wrap, timeout, withdrawal,
// done/timeout coincidence and reset during a grant.
module tb_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    rr_arbiter_if #(.NUM_REQ(32), .IDX_W(5)) bus ();

    rr_arbiter #(.NUM_REQ(32), .IDX_W(5), .MAX_HOLD(16)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] gnt, input logic [4:0] idx,
                             input logic valid, input logic to);
        check(tag, {25'b0, bus.gnt_o, bus.gnt_idx_o, bus.gnt_valid_o, bus.timeout_o},
              {25'b0, gnt, idx, valid, to});
    endtask

    initial begin
        int order [4] = '{7, 31, 0, 7};
        int prev;

        rst_n      = 1'b0;
        bus.req_i  = '0;
        bus.done_i = 1'b0;
        tick();
        tick();
        check_out("reset", 32'h0, 5'd0, 1'b0, 1'b0);

        // First grant one cycle after the request.
        rst_n     = 1'b1;
        bus.req_i = 32'h0000_0001;
        tick();
        check_out("first_grant", 32'h1, 5'd0, 1'b1, 1'b0);

        // Rotation 0 -> 7 -> 31 -> 0 -> 7 with one idle cycle between grants.
        bus.req_i = 32'h8000_0081;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            bus.done_i = 1'b1;
            tick();
            check_out("rot_idle", 32'h0, 5'(prev), 1'b0, 1'b0);
            bus.done_i = 1'b0;
            tick();
            check_out("rot_grant", 32'h1 << order[k], 5'(order[k]), 1'b1, 1'b0);
            prev = order[k];
        end

        // Reach ptr=31 by granting idx 30, then wrap to the lowest request.
        bus.req_i  = 32'h4000_0000;
        bus.done_i = 1'b1;
        tick();
        check_out("pre30_idle", 32'h0, 5'd7, 1'b0, 1'b0);
        bus.done_i = 1'b0;
        tick();
        check_out("grant30", 32'h4000_0000, 5'd30, 1'b1, 1'b0);
        bus.req_i = 32'h0000_0006;
        tick();
        check_out("withdraw30", 32'h0, 5'd30, 1'b0, 1'b0);
        tick();
        check_out("wrap_grant1", 32'h2, 5'd1, 1'b1, 1'b0);

        // Timeout: grant held for exactly 16 cycles, then a single pulse.
        bus.req_i = 32'h0;
        tick();
        check_out("drop1_idle", 32'h0, 5'd1, 1'b0, 1'b0);
        bus.req_i = 32'h0000_0010;
        tick();
        check_out("to_grant", 32'h10, 5'd4, 1'b1, 1'b0);
        for (int c = 2; c <= 16; c++) begin
            tick();
            check_out("to_hold", 32'h10, 5'd4, 1'b1, 1'b0);
        end
        tick();
        check_out("to_pulse", 32'h0, 5'd4, 1'b0, 1'b1);
        tick();
        check_out("to_regrant", 32'h10, 5'd4, 1'b1, 1'b0);

        // Withdrawal mid-grant: no timeout pulse.
        tick();
        tick();
        bus.req_i = 32'h0;
        tick();
        check_out("withdraw4", 32'h0, 5'd4, 1'b0, 1'b0);
        tick();
        check_out("withdraw4_quiet", 32'h0, 5'd4, 1'b0, 1'b0);

        // done_i on the 16th grant cycle wins over the timeout.
        bus.req_i = 32'h0000_0010;
        tick();
        check_out("co_grant", 32'h10, 5'd4, 1'b1, 1'b0);
        for (int c = 2; c <= 16; c++) tick();
        check_out("co_cycle16", 32'h10, 5'd4, 1'b1, 1'b0);
        bus.done_i = 1'b1;
        tick();
        check_out("co_release", 32'h0, 5'd4, 1'b0, 1'b0);
        bus.done_i = 1'b0;
        bus.req_i  = 32'h0;
        tick();
        check_out("co_after", 32'h0, 5'd4, 1'b0, 1'b0);

        // Reset during a grant drops it at once and clears the pointer.
        bus.req_i = 32'h0000_0200;
        tick();
        check_out("grant9", 32'h200, 5'd9, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        check_out("reset_mid", 32'h0, 5'd0, 1'b0, 1'b0);
        rst_n     = 1'b1;
        bus.req_i = 32'h0000_0202;
        tick();
        check_out("post_reset", 32'h2, 5'd1, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
